// File: rtl/video_scanlines_if.sv
// Video stream bundle (pixel enable, syncs, blanks and RGB) shared by the input
// and output sides of the scanline stage.
interface video_scanlines_if #(
  parameter int DW = 8
);
  logic          ce_pix;
  logic          hs;
  logic          vs;
  logic          hb;
  logic          vb;
  logic [DW-1:0] r;
  logic [DW-1:0] g;
  logic [DW-1:0] b;

  modport master (output ce_pix, hs, vs, hb, vb, r, g, b);
  modport slave  (input  ce_pix, hs, vs, hb, vb, r, g, b);
endinterface

// File: rtl/video_scanlines.sv
// CRT scanline emulation after the scandoubler: darkens odd output lines and
// keeps syncs/blanks aligned with the two-stage colour pipeline.
module video_scanlines #(
  parameter  int HALF_DEPTH = 0,
  localparam int DWIDTH     = (HALF_DEPTH != 0) ? 3 : 7
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [1:0]         scanlines,
  video_scanlines_if.slave   vin,
  video_scanlines_if.master  vout
);

  logic              hs_prev_q, hs_prev_d;
  logic              vs_prev_q, vs_prev_d;
  logic              parity_q,  parity_d;
  logic [1:0]        mode_q,    mode_d;
  logic              hs1_q, hs1_d, vs1_q, vs1_d, hb1_q, hb1_d, vb1_q, vb1_d;
  logic [DWIDTH:0]   r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
  logic              hs2_q, hs2_d, vs2_q, vs2_d, hb2_q, hb2_d, vb2_q, vb2_d;
  logic [DWIDTH:0]   r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
  logic              hs_rise_s, vs_rise_s, blank_s;

  // Truncating darkening; the result never exceeds c, so no overflow handling.
  function automatic logic [DWIDTH:0] dim_chan(input logic [DWIDTH:0] c,
                                               input logic [1:0]      mode,
                                               input logic            odd);
    logic [DWIDTH:0] res;
    if (odd) begin
      case (mode)
        2'd1:    res = c - (c >> 2'd2);
        2'd2:    res = c >> 2'd1;
        2'd3:    res = c >> 2'd2;
        default: res = c;
      endcase
    end else begin
      res = c;
    end
    return res;
  endfunction

  // Next-state for both pipeline stages; registers only load on a ce pulse.
  always_comb begin
    hs_rise_s = vin.hs & ~hs_prev_q;
    vs_rise_s = vin.vs & ~vs_prev_q;
    blank_s   = vin.hb | vin.vb;
    hs_prev_d = vin.hs;
    vs_prev_d = vin.vs;

    // vs wins over a simultaneous hs rise, so a new frame always starts on parity 0.
    if (vs_rise_s) begin
      parity_d = 1'b0;
      mode_d   = scanlines;
    end else if (hs_rise_s) begin
      parity_d = ~parity_q;
      mode_d   = mode_q;
    end else begin
      parity_d = parity_q;
      mode_d   = mode_q;
    end

    hs1_d = vin.hs;
    vs1_d = vin.vs;
    hb1_d = vin.hb;
    vb1_d = vin.vb;
    if (blank_s) begin
      r1_d = {(DWIDTH+1){1'b0}};
      g1_d = {(DWIDTH+1){1'b0}};
      b1_d = {(DWIDTH+1){1'b0}};
    end else begin
      r1_d = vin.r;
      g1_d = vin.g;
      b1_d = vin.b;
    end

    // parity_q/mode_q were loaded together with the stage-1 pixel they belong to.
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    hb2_d = hb1_q;
    vb2_d = vb1_q;
    r2_d  = dim_chan(r1_q, mode_q, parity_q);
    g2_d  = dim_chan(g1_q, mode_q, parity_q);
    b2_d  = dim_chan(b1_q, mode_q, parity_q);
  end

  // Pipeline and line/frame state registers, advancing on ce_pix only.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      parity_q  <= 1'b0;
      mode_q    <= 2'd0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      hb1_q     <= 1'b1;
      vb1_q     <= 1'b1;
      r1_q      <= {(DWIDTH+1){1'b0}};
      g1_q      <= {(DWIDTH+1){1'b0}};
      b1_q      <= {(DWIDTH+1){1'b0}};
      hs2_q     <= 1'b0;
      vs2_q     <= 1'b0;
      hb2_q     <= 1'b1;
      vb2_q     <= 1'b1;
      r2_q      <= {(DWIDTH+1){1'b0}};
      g2_q      <= {(DWIDTH+1){1'b0}};
      b2_q      <= {(DWIDTH+1){1'b0}};
    end else if (vin.ce_pix) begin
      hs_prev_q <= hs_prev_d;
      vs_prev_q <= vs_prev_d;
      parity_q  <= parity_d;
      mode_q    <= mode_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      hb1_q     <= hb1_d;
      vb1_q     <= vb1_d;
      r1_q      <= r1_d;
      g1_q      <= g1_d;
      b1_q      <= b1_d;
      hs2_q     <= hs2_d;
      vs2_q     <= vs2_d;
      hb2_q     <= hb2_d;
      vb2_q     <= vb2_d;
      r2_q      <= r2_d;
      g2_q      <= g2_d;
      b2_q      <= b2_d;
    end
  end

  assign vout.ce_pix = vin.ce_pix;
  assign vout.hs     = hs2_q;
  assign vout.vs     = vs2_q;
  assign vout.hb     = hb2_q;
  assign vout.vb     = vb2_q;
  assign vout.r      = r2_q;
  assign vout.g      = g2_q;
  assign vout.b      = b2_q;

endmodule

// File: tb/tb_video_scanlines.sv
// Directed bench for video_scanlines: 8-bit and 4-bit instances share stimulus and
// are checked every cycle against a line-counting reference model.
module tb_video_scanlines;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic [1:0] scanlines;

  always #5 clk_sys = ~clk_sys;

  video_scanlines_if #(.DW(8)) vin8();
  video_scanlines_if #(.DW(8)) vout8();
  video_scanlines_if #(.DW(4)) vin4();
  video_scanlines_if #(.DW(4)) vout4();

  video_scanlines #(.HALF_DEPTH(0)) dut8 (
    .clk_sys(clk_sys), .reset_n(reset_n), .scanlines(scanlines), .vin(vin8), .vout(vout8));
  video_scanlines #(.HALF_DEPTH(1)) dut4 (
    .clk_sys(clk_sys), .reset_n(reset_n), .scanlines(scanlines), .vin(vin4), .vout(vout4));

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  typedef struct {
    bit hs, vs, hb, vb;
    int r, g, b, r4, g4, b4;
  } vrec_t;

  vrec_t stg, expo, nv;
  bit    m_hs_prev, m_vs_prev, hr, vr, blank;
  int    m_line, m_mode;

  function automatic vrec_t rst_rec();
    vrec_t v;
    v.hs = 1'b0; v.vs = 1'b0; v.hb = 1'b1; v.vb = 1'b1;
    v.r = 0; v.g = 0; v.b = 0; v.r4 = 0; v.g4 = 0; v.b4 = 0;
    return v;
  endfunction

  // Odd lines (counted from the frame's vs rise) get the frame's mode applied.
  function automatic int shade(int c, int mode, int line, bit blk);
    if (blk) return 0;
    if (line % 2 == 0) return c;
    case (mode)
      1:       return c - c / 4;
      2:       return c / 2;
      3:       return c / 4;
      default: return c;
    endcase
  endfunction

  // Reference model: counts lines per frame, delays everything by two ce pulses.
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      stg = rst_rec(); expo = rst_rec();
      m_hs_prev = 1'b1; m_vs_prev = 1'b1; m_line = 0; m_mode = 0;
    end else if (vin8.ce_pix) begin
      hr = vin8.hs && !m_hs_prev;
      vr = vin8.vs && !m_vs_prev;
      if (vr) begin m_line = 0; m_mode = int'(scanlines); end
      else if (hr) m_line = m_line + 1;
      m_hs_prev = vin8.hs; m_vs_prev = vin8.vs;
      blank = vin8.hb || vin8.vb;
      nv.hs = vin8.hs; nv.vs = vin8.vs; nv.hb = vin8.hb; nv.vb = vin8.vb;
      nv.r  = shade(int'(vin8.r), m_mode, m_line, blank);
      nv.g  = shade(int'(vin8.g), m_mode, m_line, blank);
      nv.b  = shade(int'(vin8.b), m_mode, m_line, blank);
      nv.r4 = shade(int'(vin4.r), m_mode, m_line, blank);
      nv.g4 = shade(int'(vin4.g), m_mode, m_line, blank);
      nv.b4 = shade(int'(vin4.b), m_mode, m_line, blank);
      expo = stg;
      stg  = nv;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk_sys) begin
    if (chk_en) begin
      cmp("ce8", {31'd0, vout8.ce_pix}, {31'd0, vin8.ce_pix});
      cmp("hs8", {31'd0, vout8.hs}, {31'd0, expo.hs});
      cmp("vs8", {31'd0, vout8.vs}, {31'd0, expo.vs});
      cmp("hb8", {31'd0, vout8.hb}, {31'd0, expo.hb});
      cmp("vb8", {31'd0, vout8.vb}, {31'd0, expo.vb});
      cmp("r8", {24'd0, vout8.r}, expo.r);
      cmp("g8", {24'd0, vout8.g}, expo.g);
      cmp("b8", {24'd0, vout8.b}, expo.b);
      cmp("hs4", {31'd0, vout4.hs}, {31'd0, expo.hs});
      cmp("hb4", {31'd0, vout4.hb}, {31'd0, expo.hb});
      cmp("r4", {28'd0, vout4.r}, expo.r4);
      cmp("g4", {28'd0, vout4.g}, expo.g4);
      cmp("b4", {28'd0, vout4.b}, expo.b4);
    end
  end

  task automatic set_in(input bit hs, input bit vs, input bit hb, input bit vb,
                        input logic [7:0] c, input bit ce);
    vin8.ce_pix = ce; vin8.hs = hs; vin8.vs = vs; vin8.hb = hb; vin8.vb = vb;
    vin8.r = c; vin8.g = ~c; vin8.b = c;
    vin4.ce_pix = ce; vin4.hs = hs; vin4.vs = vs; vin4.hb = hb; vin4.vb = vb;
    vin4.r = c[7:4]; vin4.g = ~c[3:0]; vin4.b = c[3:0];
  endtask

  task automatic drive(input bit hs, input bit vs, input bit hb, input bit vb,
                       input logic [7:0] c, input bit ce, input int n);
    for (int i = 0; i < n; i++) begin
      set_in(hs, vs, hb, vb, c, ce);
      @(posedge clk_sys); #1;
    end
  endtask

  task automatic pix(input bit hs, input bit vs, input logic [7:0] c, input int n);
    drive(hs, vs, 1'b0, 1'b0, c, 1'b1, n);
  endtask

  // Hand-computed expectation for the red channel of both widths.
  task automatic lit(input string nm, input logic [7:0] e8, input logic [3:0] e4);
    @(negedge clk_sys);
    cmp({nm, "_r8"}, {24'd0, vout8.r}, {24'd0, e8});
    cmp({nm, "_r4"}, {28'd0, vout4.r}, {28'd0, e4});
    @(posedge clk_sys); #1;
  endtask

  task automatic odd_line_frame(input logic [1:0] mode);
    scanlines = mode;
    pix(1'b0, 1'b0, 8'hFF, 2);
    pix(1'b0, 1'b1, 8'hFF, 2);
    pix(1'b1, 1'b1, 8'hFF, 3);
  endtask

  initial begin
    reset_n   = 1'b0;
    scanlines = 2'd0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clk_sys); #1;
    chk_en = 1'b1;

    // Reset with random inputs.
    for (int i = 0; i < 5; i++) begin
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      scanlines = 2'($urandom);
      @(posedge clk_sys); #1;
    end
    @(negedge clk_sys);
    cmp("rst_r8", {24'd0, vout8.r}, 32'd0);
    cmp("rst_hb8", {31'd0, vout8.hb}, 32'd1);
    cmp("rst_vs8", {31'd0, vout8.vs}, 32'd0);
    @(posedge clk_sys); #1;

    // Release with hs/vs high: no spurious edge, so mode stays 0 on the next line.
    scanlines = 2'd2;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1);
    reset_n = 1'b1;
    pix(1'b1, 1'b1, 8'hFF, 3);
    pix(1'b0, 1'b1, 8'hFF, 2);
    pix(1'b1, 1'b1, 8'hFF, 3);
    lit("post_rst_line1", 8'hFF, 4'hF);

    // Mode 2 latched at vs rise: even lines pass, odd lines halved.
    pix(1'b0, 1'b0, 8'hFF, 2);
    pix(1'b0, 1'b1, 8'hFF, 3);
    lit("m2_line0", 8'hFF, 4'hF);
    pix(1'b1, 1'b1, 8'hFF, 3);
    lit("m2_line1", 8'h7F, 4'h7);
    pix(1'b0, 1'b0, 8'hFF, 2);
    pix(1'b1, 1'b0, 8'hFF, 3);
    lit("m2_line2", 8'hFF, 4'hF);
    pix(1'b0, 1'b0, 8'h9C, 2);
    pix(1'b1, 1'b0, 8'h9C, 3);
    lit("m2_line3_9c", 8'h4E, 4'h4);

    odd_line_frame(2'd1);
    lit("m1_odd", 8'hC0, 4'hC);
    odd_line_frame(2'd3);
    lit("m3_odd", 8'h3F, 4'h3);
    odd_line_frame(2'd0);
    lit("m0_odd", 8'hFF, 4'hF);

    // Mid-frame scanlines change has no effect until the next vs rise.
    scanlines = 2'd2;
    pix(1'b0, 1'b0, 8'hFF, 2);
    pix(1'b1, 1'b0, 8'hFF, 3);
    pix(1'b0, 1'b0, 8'hFF, 2);
    pix(1'b1, 1'b0, 8'hFF, 3);
    lit("midframe_odd", 8'hFF, 4'hF);
    pix(1'b0, 1'b0, 8'hFF, 2);
    pix(1'b0, 1'b1, 8'hFF, 2);
    pix(1'b1, 1'b1, 8'hFF, 3);
    lit("next_frame_odd", 8'h7F, 4'h7);

    // hs and vs rise together: vs wins, line 0.
    pix(1'b0, 1'b0, 8'hFF, 2);
    pix(1'b1, 1'b1, 8'hFF, 3);
    lit("hsvs_same", 8'hFF, 4'hF);
    pix(1'b0, 1'b0, 8'hFF, 2);
    pix(1'b1, 1'b0, 8'hFF, 3);
    lit("hsvs_next", 8'h7F, 4'h7);

    // Blanking forces colour to zero.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 3);
    lit("hblank", 8'h00, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 3);
    lit("vblank", 8'h00, 4'h0);

    // Sparse ce: hs toggles each pulse, outputs hold between pulses.
    for (int i = 0; i < 24; i++) begin
      drive(1'((i / 4) % 2), 1'b0, 1'b0, 1'b0, 8'(i * 11), 1'(i % 4 == 0), 1);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 1'b0, 2);
    @(negedge clk_sys);
    cmp("sparse_hold_hs", {31'd0, vout8.hs}, 32'd0);
    @(posedge clk_sys); #1;

    // Mid-frame reset returns mode to 0.
    reset_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 2);
    reset_n = 1'b1;
    pix(1'b0, 1'b0, 8'hFF, 2);
    pix(1'b1, 1'b0, 8'hFF, 3);
    lit("reset_mode0", 8'hFF, 4'hF);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
